// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Shows data as four hex digits; nibble k is lit on an[k], all outputs active low.
module seg7_scan_driver #(
    parameter int unsigned CNT_WIDTH = 20
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [15:0] data,
    output logic [6:0]  a_to_g,
    output logic [3:0]  an,
    output logic        dp
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [3:0]           an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic [1:0]           idx;
    logic [3:0]           nibble;

    // Top two counter bits select the digit, so each digit holds for 2^(CNT_WIDTH-2) cycles.
    assign idx = cnt_q[CNT_WIDTH-1 -: 2];

    always_comb begin
        nibble = 4'h0;
        unique case (idx)
            2'd0: nibble = data[3:0];
            2'd1: nibble = data[7:4];
            2'd2: nibble = data[11:8];
            2'd3: nibble = data[15:12];
            default: nibble = 4'h0;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        an_d  = ~(4'b0001 << idx);
        seg_d = 7'b1111111;
        case (nibble)
            4'h0: seg_d = 7'b0000001;
            4'h1: seg_d = 7'b1001111;
            4'h2: seg_d = 7'b0010010;
            4'h3: seg_d = 7'b0000110;
            4'h4: seg_d = 7'b1001100;
            4'h5: seg_d = 7'b0100100;
            4'h6: seg_d = 7'b0100000;
            4'h7: seg_d = 7'b0001111;
            4'h8: seg_d = 7'b0000000;
            4'h9: seg_d = 7'b0000100;
            4'hA: seg_d = 7'b0001000;
            4'hB: seg_d = 7'b1100000;
            4'hC: seg_d = 7'b0110001;
            4'hD: seg_d = 7'b1000010;
            4'hE: seg_d = 7'b0110000;
            4'hF: seg_d = 7'b0111000;
            default: seg_d = 7'b1111111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
            an_q  <= 4'b1111;
            seg_q <= 7'b1111111;
        end else begin
            cnt_q <= cnt_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an     = an_q;
    assign a_to_g = seg_q;
    assign dp     = 1'b1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with CNT_WIDTH=4 (four cycles per digit).
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [15:0] data = 16'h0000;
    logic [6:0]  a_to_g;
    logic [3:0]  an;
    logic        dp;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic [15:0] words [4] = '{16'hFEDC, 16'hBA98, 16'h7654, 16'h3210};

    seg7_scan_driver #(
        .CNT_WIDTH(4)
    ) dut (
        .clk    (clk),
        .clr    (clr),
        .data   (data),
        .a_to_g (a_to_g),
        .an     (an),
        .dp     (dp)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] an_exp, input logic [6:0] seg_exp);
        checks++;
        assert (an === an_exp) else begin
            errors++;
            $error("FAIL %s an: got %b expected %b", tag, an, an_exp);
        end
        checks++;
        assert (a_to_g === seg_exp) else begin
            errors++;
            $error("FAIL %s a_to_g: got %b expected %b", tag, a_to_g, seg_exp);
        end
        checks++;
        assert (dp === 1'b1) else begin
            errors++;
            $error("FAIL %s dp: got %b expected 1", tag, dp);
        end
    endtask

    logic [3:0] m_cnt;
    logic [3:0] exp_an;
    logic [3:0] nib;
    logic [15:0] w;

    initial begin
        // Reset held for three edges
        clr  = 1'b1;
        data = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset", 4'b1111, 7'b1111111);
        end

        // Scan order with data=1234
        clr = 1'b0;
        for (int e = 1; e <= 4; e++) begin step(); check("scan_d0", 4'b1110, 7'b1001100); end
        for (int e = 5; e <= 8; e++) begin step(); check("scan_d1", 4'b1101, 7'b0000110); end
        for (int e = 9; e <= 12; e++) begin step(); check("scan_d2", 4'b1011, 7'b0010010); end
        for (int e = 13; e <= 16; e++) begin step(); check("scan_d3", 4'b0111, 7'b1001111); end
        step();
        check("scan_wrap", 4'b1110, 7'b1001100);

        // Realign to digit 0, then a full scan per word covers all 16 glyphs
        clr = 1'b1;
        step();
        check("realign", 4'b1111, 7'b1111111);
        clr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w    = words[k];
            data = w;
            for (int e = 0; e < 16; e++) begin
                step();
                exp_an = ~(4'b0001 << (e / 4));
                nib    = w[4*(e/4) +: 4];
                check("decode", exp_an, seg_tab[nib]);
            end
        end

        // Live data change while digit 0 is active (counter is back at 0)
        data = 16'h0000;
        step();
        check("live_before", 4'b1110, 7'b0000001);
        data = 16'h000F;
        step();
        check("live_after", 4'b1110, 7'b0111000);

        // Advance to cnt=8 so the next edge is in digit 2, then pulse clr
        for (int e = 0; e < 6; e++) step();
        check("pre_mid", 4'b1101, 7'b0000001);
        clr = 1'b1;
        step();
        check("mid_reset", 4'b1111, 7'b1111111);
        clr = 1'b0;
        step();
        check("post_reset", 4'b1110, 7'b0111000);

        // Wrap: 100 edges, counter model continues from 1
        data  = 16'h8888;
        m_cnt = 4'd1;
        for (int e = 0; e < 100; e++) begin
            step();
            exp_an = ~(4'b0001 << m_cnt[3:2]);
            check("wrap", exp_an, 7'b0000000);
            m_cnt = m_cnt + 4'd1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
